// File: rtl/key_sched_engine.sv
// rtl/key_sched_engine.sv - round key expansion engine with ready/valid key output
module key_sched_engine #(
  parameter int WB = 16,
  parameter int NR = 8,
  localparam int HW = 3 * WB,
  localparam int KW = 6 * WB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] key_in,
  input  logic          key_ready,
  output logic [KW-1:0] key_out,
  output logic          key_valid,
  output logic [7:0]    round_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [7:0] LAST_ROUND = 8'(NR);

  state_t          state_q, state_d;
  logic [KW-1:0]   key_d;
  logic [7:0]      idx_d;
  logic            valid_d;
  logic            done_d;

  // 3-bit substitution applied across the three words, one bit column at a time
  function automatic logic [2:0] sbox(input logic [2:0] v);
    case (v)
      3'd0:    sbox = 3'd0;
      3'd1:    sbox = 3'd5;
      3'd2:    sbox = 3'd6;
      3'd3:    sbox = 3'd7;
      3'd4:    sbox = 3'd4;
      3'd5:    sbox = 3'd3;
      3'd6:    sbox = 3'd1;
      default: sbox = 3'd2;
    endcase
  endfunction

  // Right-half mix: wrapping constant add, column S-box, word rotations, word permutation
  function automatic logic [HW-1:0] half_mix(input logic [HW-1:0] r, input logic [7:0] c);
    logic [HW-1:0] t;
    logic [WB-1:0] a2, a1, a0, b2, b0;
    logic [2:0]    s;
    t  = r + {{(HW-8){1'b0}}, c};
    a2 = '0;
    a1 = '0;
    a0 = '0;
    for (int i = 0; i < WB; i++) begin
      s     = sbox({t[2*WB+i], t[WB+i], t[i]});
      a2[i] = s[2];
      a1[i] = s[1];
      a0[i] = s[0];
    end
    b2 = {a2[WB-2:0], a2[WB-1]};
    b0 = {a0[0], a0[WB-1:1]};
    return {b0, b2, a1};
  endfunction

  // Full round function: left half passes through and also whitens the mixed right half
  function automatic logic [KW-1:0] round_f(input logic [KW-1:0] k, input logic [7:0] c);
    return {k[KW-1:HW], half_mix(k[HW-1:0], c) ^ k[KW-1:HW]};
  endfunction

  assign busy = (state_q != IDLE);

  // Next-state and next-output decisions; abort outranks the handshake
  always_comb begin
    state_d = state_q;
    key_d   = key_out;
    idx_d   = round_idx;
    valid_d = key_valid;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          key_d   = round_f(key_in, 8'd1);
          idx_d   = 8'd1;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (key_valid && key_ready) begin
          if (round_idx == LAST_ROUND) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            key_d = round_f(key_out, round_idx + 8'd1);
            idx_d = round_idx + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_out   <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_out   <= key_d;
      round_idx <= idx_d;
      key_valid <= valid_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_key_sched_engine.sv
// tb/tb_key_sched_engine.sv - directed self-checking bench for key_sched_engine
module tb_key_sched_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, key_ready;
  logic [95:0] key_in;
  logic [95:0] key_out;
  logic        key_valid, busy, done;
  logic [7:0]  round_idx;

  logic        start1, key_ready1;
  logic [95:0] key_in1;
  logic [95:0] key_out1;
  logic        key_valid1, busy1, done1;
  logic [7:0]  round_idx1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_sched_engine #(.WB(16), .NR(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_in(key_in),
    .key_ready(key_ready), .key_out(key_out), .key_valid(key_valid),
    .round_idx(round_idx), .busy(busy), .done(done)
  );

  key_sched_engine #(.WB(16), .NR(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .key_in(key_in1),
    .key_ready(key_ready1), .key_out(key_out1), .key_valid(key_valid1),
    .round_idx(round_idx1), .busy(busy1), .done(done1)
  );

  function automatic int tbl(input int v);
    case (v)
      0: return 0;
      1: return 5;
      2: return 6;
      3: return 7;
      4: return 4;
      5: return 3;
      6: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [95:0] ref_f(input logic [95:0] k, input int c);
    logic [47:0] l, r, t, x;
    int v;
    l = k[95:48];
    r = k[47:0];
    t = r + 48'(c);
    x = '0;
    for (int i = 0; i < 16; i++) begin
      v = tbl(4 * int'(t[32+i]) + 2 * int'(t[16+i]) + int'(t[i]));
      x[16 + ((i + 1) % 16)]  = v[2];
      x[i]                    = v[1];
      x[32 + ((i + 15) % 16)] = v[0];
    end
    return {l, x ^ l};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [95:0] kexp, kin, kheld;
    int eidx, hs;

    rst = 1; start = 0; abort = 0; key_ready = 0; key_in = '0;
    start1 = 0; key_ready1 = 0; key_in1 = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_key", key_out, 96'h0);
    chk("rst_idx", round_idx, 8'd0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // start in the first cycle after reset, continuous ready
    rst = 0; start = 1; key_ready = 1; key_in = '0;
    @(negedge clk);
    start = 0;
    kexp = ref_f(96'h0, 1);
    chk("r1_hand", key_out, 96'h000000000000_800000020000);
    for (int r = 1; r <= 8; r++) begin
      chk("run_valid", key_valid, 1'b1);
      chk("run_busy", busy, 1'b1);
      chk("run_idx", round_idx, 8'(r));
      chk("run_key", key_out, kexp);
      chk("run_done", done, 1'b0);
      if (r == 2) chk("r2_hand", key_out, 96'h000000000000_000100050002);
      if (r == 8) start = 1;
      kheld = key_out;
      kexp = ref_f(kexp, r + 1);
      @(negedge clk);
    end
    start = 0;
    chk("fin_done", done, 1'b1);
    chk("fin_valid", key_valid, 1'b0);
    chk("fin_busy", busy, 1'b0);
    chk("fin_keep", key_out, kheld);
    @(negedge clk);
    chk("fin_done_pulse", done, 1'b0);
    chk("fin_start_ignored", busy, 1'b0);

    // abort alone and start+abort together in IDLE
    abort = 1;
    @(negedge clk);
    chk("idle_abort_busy", busy, 1'b0);
    start = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort_busy", busy, 1'b0);
    chk("start_abort_valid", key_valid, 1'b0);

    // random ready pattern
    kin = 96'h0123_4567_89ab_cdef_fedc_ba98;
    key_in = kin; start = 1; key_ready = 0;
    @(negedge clk);
    start = 0;
    kexp = ref_f(kin, 1); eidx = 1; hs = 0;
    for (int cyc = 0; cyc < 200 && hs < 8; cyc++) begin
      chk("rnd_valid", key_valid, 1'b1);
      chk("rnd_idx", round_idx, 8'(eidx));
      chk("rnd_key", key_out, kexp);
      key_ready = 1'($urandom_range(0, 1));
      if (key_ready) begin
        hs++;
        if (eidx < 8) begin
          eidx++;
          kexp = ref_f(kexp, eidx);
        end
      end
      @(negedge clk);
    end
    key_ready = 0;
    chk("rnd_handshakes", 96'(hs), 96'd8);
    chk("rnd_done", done, 1'b1);
    chk("rnd_valid_end", key_valid, 1'b0);

    // abort at round 3 together with ready
    key_in = kin; start = 1; key_ready = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("ab_idx3", round_idx, 8'd3);
    kheld = key_out;
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("ab_valid", key_valid, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    chk("ab_keep", key_out, kheld);
    start = 1;
    @(negedge clk);
    chk("ab_done_after", done, 1'b0);
    chk("ab_restart_idx", round_idx, 8'd1);
    chk("ab_restart_key", key_out, ref_f(kin, 1));

    // mid-run start ignored, then reset at round 5
    start = 0;
    kexp = ref_f(kin, 1);
    for (int r = 1; r < 5; r++) begin
      if (r == 3) start = 1;
      kexp = ref_f(kexp, r + 1);
      @(negedge clk);
      start = 0;
    end
    chk("rs_idx5", round_idx, 8'd5);
    chk("rs_key5", key_out, kexp);
    rst = 1; start = 1;
    @(negedge clk);
    chk("rs_key", key_out, 96'h0);
    chk("rs_idx", round_idx, 8'd0);
    chk("rs_valid", key_valid, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", done, 1'b0);
    rst = 0; start = 0; key_ready = 0;
    @(negedge clk);

    // NR=1 instance with carry wrap of the round constant
    key_in1 = {48'h123456789abc, 48'hffffffffffff};
    start1 = 1; key_ready1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("nr1_valid", key_valid1, 1'b1);
    chk("nr1_idx", round_idx1, 8'd1);
    chk("nr1_key", key_out1, 96'h123456789abc_123456789abc);
    @(negedge clk);
    chk("nr1_done", done1, 1'b1);
    chk("nr1_valid_end", key_valid1, 1'b0);
    chk("nr1_busy", busy1, 1'b0);
    @(negedge clk);
    chk("nr1_done_pulse", done1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
